// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data bus interface between the memory stage and the data memory
//
// Purpose: groups the request/acknowledge data bus into one bundle.
// Ports (signals):
//   dbus_req_o    stage -> mem  request, held until acknowledged
//   dbus_we_o     stage -> mem  1 = write
//   dbus_addr_o   stage -> mem  word-aligned address
//   dbus_wdata_o  stage -> mem  lane-replicated write data
//   dbus_be_o     stage -> mem  byte enables
//   dbus_rdata_i  mem -> stage  read data, valid with ack
//   dbus_ack_i    mem -> stage  transaction complete
// Modports: master (memory stage side), slave (memory side).

interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            dbus_req_o;
    logic            dbus_we_o;
    logic [XLEN-1:0] dbus_addr_o;
    logic [XLEN-1:0] dbus_wdata_o;
    logic [3:0]      dbus_be_o;
    logic [XLEN-1:0] dbus_rdata_i;
    logic            dbus_ack_i;

    modport master (
        output dbus_req_o,
        output dbus_we_o,
        output dbus_addr_o,
        output dbus_wdata_o,
        output dbus_be_o,
        input  dbus_rdata_i,
        input  dbus_ack_i
    );

    modport slave (
        input  dbus_req_o,
        input  dbus_we_o,
        input  dbus_addr_o,
        input  dbus_wdata_o,
        input  dbus_be_o,
        output dbus_rdata_i,
        output dbus_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with request/ack data bus
//
// Purpose: takes the execute stage result, passes ALU results to writeback
// with one cycle of latency, and runs load/store transactions on the data bus
// (sizing, lane alignment, sign/zero extension, misalignment detection).
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   valid_i             execute output valid
//   rd_addr_i/rd_data_i/rd_we_i  execute result; rd_data_i is the address for memory ops
//   mem_en_i, mem_wr_i, mem_func3_i, store_data_i  load/store controls
//   stall_o             upstream must hold its outputs
//   dbus                data bus (master side)
//   rd_addr_o/rd_data_o/rd_we_o  registered writeback triple
//   misalign_o          one-cycle pulse when an illegal access is dropped

module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rd_we_i,
    input  logic            mem_en_i,
    input  logic            mem_wr_i,
    input  logic [2:0]      mem_func3_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            stall_o,
    mem_stage_if.master     dbus,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_we_o,
    output logic            misalign_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t          state;

    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;

    // Transaction context kept for the writeback once the ack arrives.
    logic [4:0]      rd_lat;
    logic [1:0]      off_lat;
    logic [2:0]      f3_lat;
    logic            wr_lat;

    logic [1:0]      off;
    logic            legal;
    logic            mem_start;
    logic [3:0]      be_enc;
    logic [XLEN-1:0] wdata_enc;
    logic [XLEN-1:0] rshift;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_data;

    assign off = rd_data_i[1:0];

    // Legality: size/alignment check plus the funct3 codes each direction defines.
    always_comb begin
        legal = 1'b0;
        case (mem_func3_i)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !off[0];
            F3_W:    legal = (off == 2'b00);
            F3_BU:   legal = !mem_wr_i;
            F3_HU:   legal = !mem_wr_i && !off[0];
            default: legal = 1'b0;
        endcase
    end

    assign mem_start = valid_i && mem_en_i && legal;

    // Store lane encoding: data is replicated so the enabled lanes always carry it.
    always_comb begin
        be_enc    = 4'b1111;
        wdata_enc = store_data_i;
        case (mem_func3_i)
            F3_B: begin
                be_enc    = 4'b0001 << off;
                wdata_enc = {4{store_data_i[7:0]}};
            end
            F3_H: begin
                be_enc    = 4'b0011 << {off[1], 1'b0};
                wdata_enc = {2{store_data_i[15:0]}};
            end
            default: begin
                be_enc    = 4'b1111;
                wdata_enc = store_data_i;
            end
        endcase
    end

    // Load formatting from the latched lane offset.
    assign rshift = dbus.dbus_rdata_i >> {off_lat, 3'b000};
    assign lane_b = rshift[7:0];
    assign lane_h = off_lat[1] ? dbus.dbus_rdata_i[31:16] : dbus.dbus_rdata_i[15:0];

    always_comb begin
        load_data = dbus.dbus_rdata_i;
        case (f3_lat)
            F3_B:    load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, lane_b};
            F3_H:    load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, lane_h};
            default: load_data = dbus.dbus_rdata_i;
        endcase
    end

    // Stall is combinational so the request cycle itself already holds upstream.
    assign stall_o = (state == IDLE) ? mem_start : !dbus.dbus_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            rd_lat     <= 5'd0;
            off_lat    <= 2'b00;
            f3_lat     <= 3'b000;
            wr_lat     <= 1'b0;
            rd_addr_o  <= 5'd0;
            rd_data_o  <= '0;
            rd_we_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && !mem_en_i) begin
                        rd_addr_o <= rd_addr_i;
                        rd_data_o <= rd_data_i;
                        rd_we_o   <= rd_we_i;
                    end else if (valid_i && mem_en_i) begin
                        rd_we_o <= 1'b0;
                        if (legal) begin
                            req_q   <= 1'b1;
                            we_q    <= mem_wr_i;
                            addr_q  <= {rd_data_i[XLEN-1:2], 2'b00};
                            wdata_q <= mem_wr_i ? wdata_enc : '0;
                            be_q    <= mem_wr_i ? be_enc : 4'b1111;
                            rd_lat  <= rd_addr_i;
                            off_lat <= off;
                            f3_lat  <= mem_func3_i;
                            wr_lat  <= mem_wr_i;
                            state   <= WAIT;
                        end else begin
                            misalign_o <= 1'b1;
                        end
                    end else begin
                        rd_we_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dbus.dbus_ack_i) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                        if (!wr_lat) begin
                            rd_addr_o <= rd_lat;
                            rd_data_o <= load_data;
                            rd_we_o   <= (rd_lat != 5'd0);
                        end else begin
                            rd_we_o <= 1'b0;
                        end
                    end else begin
                        rd_we_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbus.dbus_req_o   = req_q;
    assign dbus.dbus_we_o    = we_q;
    assign dbus.dbus_addr_o  = addr_q;
    assign dbus.dbus_wdata_o = wdata_q;
    assign dbus.dbus_be_o    = be_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking testbench for mem_stage

module tb_mem_stage;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_we_i;
    logic        mem_en_i;
    logic        mem_wr_i;
    logic [2:0]  mem_func3_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_we_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic        cap_req;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    int          stalls;

    mem_stage_if #(.XLEN(32)) dbus ();

    mem_stage #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .rd_we_i      (rd_we_i),
        .mem_en_i     (mem_en_i),
        .mem_wr_i     (mem_wr_i),
        .mem_func3_i  (mem_func3_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .dbus         (dbus.master),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_we_o      (rd_we_o),
        .misalign_o   (misalign_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk_i);
        valid_i           = 1'b0;
        mem_en_i          = 1'b0;
        dbus.dbus_ack_i   = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data, input logic we);
        @(negedge clk_i);
        valid_i         = 1'b1;
        mem_en_i        = 1'b0;
        rd_addr_i       = rd;
        rd_data_i       = data;
        rd_we_i         = we;
        dbus.dbus_ack_i = 1'b0;
        #1 check("alu_stall", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
    endtask

    // Issues one legal memory op, acks after 'waits' idle wait cycles, returns
    // just after the ack edge with the bus snapshot from the request edge.
    task automatic do_mem(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int waits,
                          input logic [31:0] rdata, output int n_stall);
        n_stall = 0;
        @(negedge clk_i);
        valid_i         = 1'b1;
        mem_en_i        = 1'b1;
        mem_wr_i        = wr;
        mem_func3_i     = f3;
        rd_data_i       = addr;
        store_data_i    = sdata;
        rd_addr_i       = rd;
        rd_we_i         = !wr;
        dbus.dbus_ack_i = 1'b0;
        #1 if (stall_o) n_stall++;
        @(posedge clk_i);
        #1;
        cap_req   = dbus.dbus_req_o;
        cap_we    = dbus.dbus_we_o;
        cap_addr  = dbus.dbus_addr_o;
        cap_wdata = dbus.dbus_wdata_o;
        cap_be    = dbus.dbus_be_o;
        check("req_edge_wb", rd_we_o, 1'b0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk_i);
            #1 if (stall_o) n_stall++;
            @(posedge clk_i);
            #1;
            check("wait_req_held", dbus.dbus_req_o, 1'b1);
            check("wait_addr_held", dbus.dbus_addr_o, {addr[31:2], 2'b00});
            check("wait_wb_off", rd_we_o, 1'b0);
        end
        @(negedge clk_i);
        dbus.dbus_ack_i   = 1'b1;
        dbus.dbus_rdata_i = rdata;
        #1 if (stall_o) n_stall++;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i             = 1'b0;
        valid_i           = 1'b0;
        rd_addr_i         = 5'd0;
        rd_data_i         = 32'd0;
        rd_we_i           = 1'b0;
        mem_en_i          = 1'b0;
        mem_wr_i          = 1'b0;
        mem_func3_i       = 3'b000;
        store_data_i      = 32'd0;
        dbus.dbus_ack_i   = 1'b0;
        dbus.dbus_rdata_i = 32'd0;

        // Reset state
        #23;
        check("rst_req", dbus.dbus_req_o, 1'b0);
        check("rst_we", dbus.dbus_we_o, 1'b0);
        check("rst_addr", dbus.dbus_addr_o, 32'd0);
        check("rst_wdata", dbus.dbus_wdata_o, 32'd0);
        check("rst_be", dbus.dbus_be_o, 4'd0);
        check("rst_rd_addr", rd_addr_o, 5'd0);
        check("rst_rd_data", rd_data_o, 32'd0);
        check("rst_rd_we", rd_we_o, 1'b0);
        check("rst_misalign", misalign_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ALU pass-through and bubble
        alu(5'd5, 32'h0000_1234, 1'b1);
        check("alu_rd_addr", rd_addr_o, 5'd5);
        check("alu_rd_data", rd_data_o, 32'h0000_1234);
        check("alu_rd_we", rd_we_o, 1'b1);
        idle();
        @(posedge clk_i);
        #1 check("bubble_rd_we", rd_we_o, 1'b0);

        // SB 0xA5 to 0x103, ack after 3 wait cycles
        do_mem(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0, 3, 32'd0, stalls);
        check("sb_req", cap_req, 1'b1);
        check("sb_we", cap_we, 1'b1);
        check("sb_addr", cap_addr, 32'h0000_0100);
        check("sb_be", cap_be, 4'b1000);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb_stall_cycles", stalls, 4);
        check("sb_req_drop", dbus.dbus_req_o, 1'b0);
        check("sb_wb", rd_we_o, 1'b0);
        idle();

        // SH to 0x102 and SW to 0x104, immediate ack
        do_mem(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5'd0, 0, 32'd0, stalls);
        check("sh_be", cap_be, 4'b1100);
        check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_stall_cycles", stalls, 1);
        do_mem(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 0, 32'd0, stalls);
        check("sw_addr", cap_addr, 32'h0000_0104);
        check("sw_be", cap_be, 4'b1111);
        check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);

        // Loads from 0x202 with rdata 0x0080FF00, ack after 1 wait cycle
        do_mem(1'b0, 3'b000, 32'h0000_0202, 32'd0, 5'd7, 1, 32'h0080_FF00, stalls);
        check("lb_req_we", {31'd0, cap_we}, 32'd0);
        check("lb_addr", cap_addr, 32'h0000_0200);
        check("lb_stall_cycles", stalls, 2);
        check("lb_data", rd_data_o, 32'hFFFF_FF80);
        check("lb_rd_addr", rd_addr_o, 5'd7);
        check("lb_rd_we", rd_we_o, 1'b1);
        do_mem(1'b0, 3'b100, 32'h0000_0202, 32'd0, 5'd7, 1, 32'h0080_FF00, stalls);
        check("lbu_data", rd_data_o, 32'h0000_0080);
        do_mem(1'b0, 3'b001, 32'h0000_0202, 32'd0, 5'd8, 1, 32'h0080_FF00, stalls);
        check("lh_hi_data", rd_data_o, 32'h0000_0080);
        check("lh_rd_addr", rd_addr_o, 5'd8);
        do_mem(1'b0, 3'b001, 32'h0000_0200, 32'd0, 5'd8, 0, 32'h0080_FF00, stalls);
        check("lh_lo_data", rd_data_o, 32'hFFFF_FF00);
        do_mem(1'b0, 3'b101, 32'h0000_0200, 32'd0, 5'd8, 0, 32'h0080_FF00, stalls);
        check("lhu_data", rd_data_o, 32'h0000_FF00);
        do_mem(1'b0, 3'b000, 32'h0000_0201, 32'd0, 5'd9, 0, 32'h0080_FF00, stalls);
        check("lb1_data", rd_data_o, 32'hFFFF_FFFF);
        do_mem(1'b0, 3'b010, 32'h0000_0208, 32'd0, 5'd9, 2, 32'hCAFE_F00D, stalls);
        check("lw_data", rd_data_o, 32'hCAFE_F00D);
        check("lw_misalign_quiet", misalign_o, 1'b0);
        idle();
        @(posedge clk_i);
        #1 check("post_load_bubble", rd_we_o, 1'b0);

        // Misaligned LW to 0x101
        @(negedge clk_i);
        valid_i     = 1'b1;
        mem_en_i    = 1'b1;
        mem_wr_i    = 1'b0;
        mem_func3_i = 3'b010;
        rd_data_i   = 32'h0000_0101;
        rd_addr_i   = 5'd4;
        rd_we_i     = 1'b1;
        #1 check("mis_stall", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("mis_pulse", misalign_o, 1'b1);
        check("mis_req", dbus.dbus_req_o, 1'b0);
        check("mis_wb", rd_we_o, 1'b0);
        idle();
        @(posedge clk_i);
        #1 check("mis_pulse_end", misalign_o, 1'b0);

        // Store with undefined funct3 011
        @(negedge clk_i);
        valid_i     = 1'b1;
        mem_en_i    = 1'b1;
        mem_wr_i    = 1'b1;
        mem_func3_i = 3'b011;
        rd_data_i   = 32'h0000_0100;
        #1 check("ill_st_stall", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("ill_st_pulse", misalign_o, 1'b1);
        check("ill_st_req", dbus.dbus_req_o, 1'b0);
        idle();

        // Reset during WAIT, ack arriving after release is ignored
        @(negedge clk_i);
        valid_i     = 1'b1;
        mem_en_i    = 1'b1;
        mem_wr_i    = 1'b0;
        mem_func3_i = 3'b010;
        rd_data_i   = 32'h0000_0100;
        rd_addr_i   = 5'd3;
        rd_we_i     = 1'b1;
        @(posedge clk_i);
        #1 check("rw_req_up", dbus.dbus_req_o, 1'b1);
        @(negedge clk_i);
        rst_i    = 1'b0;
        valid_i  = 1'b0;
        mem_en_i = 1'b0;
        #1 check("rw_req_async", dbus.dbus_req_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i             = 1'b1;
        dbus.dbus_ack_i   = 1'b1;
        dbus.dbus_rdata_i = 32'h1111_1111;
        #1 check("rw_stall_idle", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("rw_req_low", dbus.dbus_req_o, 1'b0);
        check("rw_no_wb", rd_we_o, 1'b0);
        check("rw_rd_data", rd_data_o, 32'd0);
        alu(5'd6, 32'h0000_00C3, 1'b1);
        check("rw_alu_data", rd_data_o, 32'h0000_00C3);
        check("rw_alu_we", rd_we_o, 1'b1);

        // LW to x0, then an immediately following ALU op
        do_mem(1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd0, 1, 32'h7777_7777, stalls);
        check("x0_rd_we", rd_we_o, 1'b0);
        alu(5'd9, 32'h0000_55AA, 1'b1);
        check("x0_next_alu_addr", rd_addr_o, 5'd9);
        check("x0_next_alu_data", rd_data_o, 32'h0000_55AA);
        check("x0_next_alu_we", rd_we_o, 1'b1);
        idle();
        @(posedge clk_i);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
